// File: rtl/layer2_pkg.sv
// ============================================================================
// layer2_pkg : shared defaults and state encoding for the layer-2 feature rx
// Revision   : 1.0
// ============================================================================
`default_nettype none

package layer2_pkg;

   localparam int C_COL_NUM  = 208;
   localparam int C_ROW_FULL = 19;
   localparam int C_ROW_TAIL = 4;
   localparam int C_TX_LAST  = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_ERR  = 2'd2,
      ST_DONE = 2'd3
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/layer2_rx_addr_gen.sv
// ============================================================================
// layer2_rx_addr_gen : col/row beat counters, final-beat detect, row offset
// Revision           : 1.0
// ============================================================================
`default_nettype none

module layer2_rx_addr_gen
   import layer2_pkg::*;
#(
   parameter int COL_NUM = C_COL_NUM
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        clear,
   input  logic        advance,
   input  logic [7:0]  exp_rows,
   output logic [11:0] offset,
   output logic        final_beat
);

   logic [7:0] r_col_cnt;
   logic [7:0] r_row_cnt;
   logic       w_col_end;
   logic       w_row_end;

   assign w_col_end  = (r_col_cnt == 8'(COL_NUM - 1));
   assign w_row_end  = (r_row_cnt == (exp_rows - 8'd1));
   assign final_beat = w_col_end & w_row_end;
   assign offset     = 12'(r_row_cnt) * 12'(COL_NUM) + 12'(r_col_cnt);

   // The row counter saturates on the last expected row so overlong
   // transfers keep rewriting that row instead of running off the buffer.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else if (clear) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else if (advance) begin
         if (w_col_end) begin
            r_col_cnt <= '0;
            if (!w_row_end) begin
               r_row_cnt <= r_row_cnt + 8'd1;
            end
         end else begin
            r_col_cnt <= r_col_cnt + 8'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/layer2_feature_rx.sv
// ============================================================================
// layer2_feature_rx : receives feature rows into a banked write buffer
// Optional length/last checking enabled by defining FEATURE_RX_CHK_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module layer2_feature_rx
   import layer2_pkg::*;
#(
   parameter int COL_NUM  = C_COL_NUM,
   parameter int ROW_FULL = C_ROW_FULL,
   parameter int ROW_TAIL = C_ROW_TAIL,
   parameter int TX_LAST  = C_TX_LAST
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic [63:0] feature_data,
   input  logic        feature_valid,
   input  logic        feature_last,
   output logic        ready,
   input  logic        start,
   input  logic [7:0]  tx_cnt,
   input  logic [7:0]  batch_cnt,
   input  logic        buf_afull,
   output logic        wr_en,
   output logic [12:0] wr_addr,
   output logic [63:0] wr_data,
   output logic        rx_done,
   output logic        rx_err
);

   rx_state_t   r_state;
   rx_state_t   w_state_nxt;
   logic        r_bank;
   logic [7:0]  r_exp_rows;
   logic        w_start_ok;
   logic        w_accept;
   logic        w_recv_beat;
   logic        w_final;
   logic [11:0] w_offset;
   logic        w_unused;

   assign w_start_ok  = (r_state == ST_IDLE) & start;
   assign ready       = ((r_state == ST_RECV) | (r_state == ST_ERR)) & ~buf_afull;
   assign w_accept    = feature_valid & ready;
   assign w_recv_beat = w_accept & (r_state == ST_RECV);
   assign rx_done     = (r_state == ST_DONE);

   layer2_rx_addr_gen #(
      .COL_NUM    (COL_NUM)
   ) u_addr_gen (
      .sclk       (sclk),
      .s_rst_n    (s_rst_n),
      .clear      (w_start_ok),
      .advance    (w_recv_beat),
      .exp_rows   (r_exp_rows),
      .offset     (w_offset),
      .final_beat (w_final)
   );

`ifdef FEATURE_RX_CHK_EN
   logic w_set_err;
   logic r_rx_err;

   assign w_unused = ^batch_cnt[7:1];
   assign rx_err   = r_rx_err;
`else
   assign w_unused = ^{batch_cnt[7:1], w_final};
   assign rx_err   = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
`ifdef FEATURE_RX_CHK_EN
      w_set_err   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            if (w_accept) begin
`ifdef FEATURE_RX_CHK_EN
               // Either a premature last or a missing last on the final beat.
               if (feature_last && w_final) begin
                  w_state_nxt = ST_DONE;
               end else if (feature_last || w_final) begin
                  w_state_nxt = ST_ERR;
                  w_set_err   = 1'b1;
               end
`else
               if (feature_last) begin
                  w_state_nxt = ST_DONE;
               end
`endif
            end
         end
         ST_ERR: begin
            if (w_accept && feature_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_state    <= ST_IDLE;
         r_bank     <= 1'b0;
         r_exp_rows <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         r_state <= w_state_nxt;
         wr_en   <= w_recv_beat;
         if (w_start_ok) begin
            r_exp_rows <= (tx_cnt == 8'(TX_LAST)) ? 8'(ROW_TAIL) : 8'(ROW_FULL);
            r_bank     <= batch_cnt[0];
         end
         if (w_recv_beat) begin
            wr_addr <= {r_bank, w_offset};
            wr_data <= feature_data;
         end
      end
   end

`ifdef FEATURE_RX_CHK_EN
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_rx_err <= 1'b0;
      end else if (w_start_ok) begin
         r_rx_err <= 1'b0;
      end else if (w_set_err) begin
         r_rx_err <= 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer2_feature_rx.sv
// ============================================================================
// tb_layer2_feature_rx : randomized directed bench with a transfer-level model
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_layer2_feature_rx;

   logic        sclk = 1'b0;
   logic        s_rst_n = 1'b0;
   logic [63:0] feature_data = '0;
   logic        feature_valid = 1'b0;
   logic        feature_last = 1'b0;
   logic        ready;
   logic        start = 1'b0;
   logic [7:0]  tx_cnt = '0;
   logic [7:0]  batch_cnt = '0;
   logic        buf_afull = 1'b0;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [63:0] wr_data;
   logic        rx_done;
   logic        rx_err;

   always #5 sclk = ~sclk;

   layer2_feature_rx dut (
      .sclk          (sclk),
      .s_rst_n       (s_rst_n),
      .feature_data  (feature_data),
      .feature_valid (feature_valid),
      .feature_last  (feature_last),
      .ready         (ready),
      .start         (start),
      .tx_cnt        (tx_cnt),
      .batch_cnt     (batch_cnt),
      .buf_afull     (buf_afull),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rx_done       (rx_done),
      .rx_err        (rx_err)
   );

   int n_cmp = 0;
   int n_err = 0;
   int neg_cnt = 0;
   int done_cnt = 0;
   int done_neg = 0;
   logic [12:0] wq_addr[$];
   logic [63:0] wq_data[$];
   logic [63:0] dq[$];

   always @(negedge sclk) begin
      neg_cnt++;
      if (rx_done) begin
         done_cnt++;
         done_neg = neg_cnt;
      end
      if (wr_en) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Buffer offset of the i-th written beat: linear inside the transfer,
   // then the last row is reused once the row count is exhausted.
   function automatic int off_model(input int i, input int rows);
      int base;
      base = (rows - 1) * 208;
      if (i < rows * 208) return i;
      return base + (i - base) % 208;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, ":ready"},   ready,   0);
      check({tag, ":wr_en"},   wr_en,   0);
      check({tag, ":wr_addr"}, wr_addr, 0);
      check({tag, ":wr_data"}, wr_data, 0);
      check({tag, ":rx_done"}, rx_done, 0);
      check({tag, ":rx_err"},  rx_err,  0);
   endtask

   task automatic run_xfer(input string tag, input int tx, input int batch, input int last_at,
                           input bit stall, input bit restart);
      int rows, total, n_exp, i, acc_neg, bad, first_bad, lim, viol, n_cmpw;
      bit acc, err_exp;
      rows  = (tx == 12) ? 4 : 19;
      total = rows * 208;
`ifdef FEATURE_RX_CHK_EN
      n_exp   = (last_at < total) ? last_at + 1 : total;
      err_exp = (last_at != total - 1);
`else
      n_exp   = last_at + 1;
      err_exp = 1'b0;
`endif
      wq_addr.delete(); wq_data.delete(); dq.delete();
      done_cnt = 0; viol = 0; acc_neg = -100;
      @(negedge sclk);
      start = 1'b1; tx_cnt = 8'(tx); batch_cnt = 8'(batch);
      @(negedge sclk);
      start = 1'b0;
      i = 0;
      lim = neg_cnt + 30000;
      while (i <= last_at && neg_cnt < lim) begin
         feature_valid = ($urandom_range(0, 3) != 0);
         feature_data  = {$urandom, $urandom};
         feature_last  = (i == last_at);
         buf_afull     = stall ? (((neg_cnt / 3) % 2) == 1) : 1'b0;
         start         = restart && (i == 50);
         if (start) begin
            tx_cnt = 8'd12; batch_cnt = 8'(batch + 1);
         end
         #1;
         acc = feature_valid && ready;
         if (buf_afull && ready) viol++;
         if (acc) begin
            dq.push_back(feature_data);
            if (i == last_at) acc_neg = neg_cnt;
            i++;
         end
         @(negedge sclk);
      end
      feature_valid = 1'b0; feature_last = 1'b0; buf_afull = 1'b0; start = 1'b0;
      check({tag, ":beats_accepted"}, i, last_at + 1);
      for (int k = 0; k < 10 && done_cnt == 0; k++) @(negedge sclk);
      repeat (3) @(negedge sclk);
      check({tag, ":wr_count"}, wq_addr.size(), n_exp);
      bad = 0; first_bad = -1;
      n_cmpw = (wq_addr.size() < n_exp) ? wq_addr.size() : n_exp;
      for (int j = 0; j < n_cmpw; j++) begin
         if (wq_addr[j] !== 13'(batch % 2 * 4096 + off_model(j, rows)) || wq_data[j] !== dq[j]) begin
            bad++;
            if (first_bad < 0) first_bad = j;
         end
      end
      if (first_bad >= 0)
         $display("  %s: first bad write %0d addr %0h data %0h", tag, first_bad,
                  wq_addr[first_bad], wq_data[first_bad]);
      check({tag, ":wr_seq_bad"}, bad, 0);
      check({tag, ":done_cnt"}, done_cnt, 1);
      check({tag, ":done_latency"}, done_neg, acc_neg + 1);
      check({tag, ":rx_err"}, rx_err, err_exp);
      check({tag, ":ready_while_afull"}, viol, 0);
      check({tag, ":ready_after_done"}, ready, 0);
   endtask

   initial begin
      int acc_n, guard;
      repeat (2) @(negedge sclk);
      #1;
      check_idle_outputs("rst_hold");
      @(negedge sclk);
      s_rst_n = 1'b1;
      @(negedge sclk);
      #1;
      check_idle_outputs("rst_release");

      run_xfer("full_bank0",  0,  0, 3951, 1'b0, 1'b1);
      run_xfer("tail_bank1", 12,  1,  831, 1'b0, 1'b0);
      run_xfer("early100",    0,  0,  100, 1'b0, 1'b0);
      run_xfer("tail_stall", 12,  0,  831, 1'b1, 1'b0);
      run_xfer("early10",     5,  2,   10, 1'b0, 1'b0);
      run_xfer("no_last",    12,  1,  900, 1'b0, 1'b0);

      // Abort a transfer mid-way with an asynchronous reset.
      @(negedge sclk);
      start = 1'b1; tx_cnt = 8'd0; batch_cnt = 8'd1;
      @(negedge sclk);
      start = 1'b0;
      acc_n = 0; guard = 0;
      while (acc_n < 501 && guard < 2000) begin
         feature_valid = 1'b1;
         feature_data  = {$urandom, $urandom};
         #1;
         if (ready) acc_n++;
         guard++;
         @(negedge sclk);
      end
      feature_valid = 1'b0;
      check("mid_rst:beats_accepted", acc_n, 501);
      check("mid_rst:wr_addr_before", wr_addr, 13'h1000 + 13'd500);
      #2;
      s_rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      @(negedge sclk);
      s_rst_n = 1'b1;
      run_xfer("post_rst", 12, 0, 831, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
